// File: rtl/rsa_feeder.sv
// Edge feeder for a ROWS x COLS systolic array: takes operand beats, builds
// stage-0 slots per job and skews them so lane i/j reach the array i/j cycles late.
module rsa_feeder #(
  parameter int RSA_DW = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 4
) (
  input  logic                     clk,
  input  logic                     sys_rst,
  input  logic                     start,
  input  logic [7:0]               k_len,
  input  logic [1:0]               mode_in,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*RSA_DW-1:0]   a_vec,
  input  logic [COLS*RSA_DW-1:0]   b_vec,
  output logic [1:0]               PE_mode,
  output logic [ROWS*RSA_DW-1:0]   h_data,
  output logic [COLS*RSA_DW-1:0]   v_data,
  output logic [COLS-1:0]          cal_en,
  output logic [COLS-1:0]          cal_done
);

  localparam int MAXRC     = (ROWS > COLS) ? ROWS : COLS;
  localparam int DRAIN_LEN = MAXRC - 1;
  localparam int DCW       = (MAXRC > 1) ? $clog2(MAXRC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, TAIL, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [7:0]     kLen_q, kLen_d;
  logic [7:0]     beatCnt_q, beatCnt_d;
  logic [DCW-1:0] drainCnt_q, drainCnt_d;
  logic [1:0]     mode_q, mode_d;
  logic           done_q, done_d;
  logic           slotEn, slotDone, passData;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      kLen_q     <= '0;
      beatCnt_q  <= '0;
      drainCnt_q <= '0;
      mode_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kLen_q     <= kLen_d;
      beatCnt_q  <= beatCnt_d;
      drainCnt_q <= drainCnt_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kLen_d     = kLen_q;
    beatCnt_d  = beatCnt_q;
    drainCnt_d = drainCnt_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    slotEn     = 1'b0;
    slotDone   = 1'b0;
    passData   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (k_len != 8'd0)) begin
          kLen_d    = k_len;
          mode_d    = mode_in;
          beatCnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Bubbles still fire cal_en with zero data so the dot products stay aligned.
        slotEn = 1'b1;
        if (in_valid) begin
          passData  = 1'b1;
          beatCnt_d = beatCnt_q + 8'd1;
          if (beatCnt_q + 8'd1 == kLen_q) state_d = TAIL;
        end
      end
      TAIL: begin
        slotDone = 1'b1;
        if (DRAIN_LEN == 0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drainCnt_d = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        drainCnt_d = drainCnt_q + DCW'(1);
        if (drainCnt_q == DCW'(DRAIN_LEN - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == RUN);
  assign done     = done_q;
  assign PE_mode  = mode_q;

  // Lane i keeps i+1 stages: stage 0 is the slot register, the rest is skew.
  for (genvar i = 0; i < ROWS; i++) begin : gRow
    logic [RSA_DW-1:0] pipe_q [0:i];
    always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
        for (int k = 0; k <= i; k++) pipe_q[k] <= '0;
      end else begin
        pipe_q[0] <= passData ? a_vec[i*RSA_DW +: RSA_DW] : '0;
        for (int k = 1; k <= i; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end
    assign h_data[i*RSA_DW +: RSA_DW] = pipe_q[i];
  end

  for (genvar j = 0; j < COLS; j++) begin : gCol
    logic [RSA_DW+1:0] pipe_q [0:j];
    always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
        for (int k = 0; k <= j; k++) pipe_q[k] <= '0;
      end else begin
        pipe_q[0] <= {slotDone, slotEn, passData ? b_vec[j*RSA_DW +: RSA_DW] : {RSA_DW{1'b0}}};
        for (int k = 1; k <= j; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end
    assign v_data[j*RSA_DW +: RSA_DW] = pipe_q[j][RSA_DW-1:0];
    assign cal_en[j]                  = pipe_q[j][RSA_DW];
    assign cal_done[j]                = pipe_q[j][RSA_DW+1];
  end

endmodule

// File: tb/tb_rsa_feeder.sv
// Randomized scoreboard bench for rsa_feeder: the driver predicts each job's slot
// stream and done cycle, a negedge monitor pops per-lane expectations as lanes fire.
module tb_rsa_feeder;

  localparam int DW = 16;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int D  = ((R > C) ? R : C) - 1;

  logic            clk = 1'b0;
  logic            sys_rst;
  logic            start;
  logic [7:0]      k_len;
  logic [1:0]      mode_in;
  logic            busy, done, in_valid, in_ready;
  logic [R*DW-1:0] a_vec;
  logic [C*DW-1:0] b_vec;
  logic [1:0]      PE_mode;
  logic [R*DW-1:0] h_data;
  logic [C*DW-1:0] v_data;
  logic [C-1:0]    cal_en, cal_done;

  rsa_feeder #(.RSA_DW(DW), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .k_len(k_len), .mode_in(mode_in),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .PE_mode(PE_mode), .h_data(h_data),
    .v_data(v_data), .cal_en(cal_en), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int            cyc;
    logic          en;
    logic          dn;
    logic [DW-1:0] h;
    logic [DW-1:0] v;
  } slot_t;

  slot_t laneQ [C][$];
  int    doneQ [$];
  int    nTests = 0;
  int    nFail  = 0;
  logic       expBusy = 1'b0;
  logic       expReady = 1'b0;
  logic [1:0] expMode = 2'b00;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic failNow(input string name, input int act, input int exp);
    nTests++;
    nFail++;
    $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cycle, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares status every cycle and pops a lane's expectation whenever it fires.
  slot_t         mSlot;
  logic [DW-1:0] mH, mV;
  always @(negedge clk) begin
    checkOutput("busy", 64'(busy), 64'(expBusy));
    checkOutput("in_ready", 64'(in_ready), 64'(expReady));
    checkOutput("PE_mode", 64'(PE_mode), 64'(expMode));
    for (int j = 0; j < C; j++) begin
      mH = h_data[j*DW +: DW];
      mV = v_data[j*DW +: DW];
      if (cal_en[j] || cal_done[j]) begin
        if (laneQ[j].size() == 0) begin
          failNow($sformatf("lane%0d_unexpected_slot", j), 1, 0);
        end else begin
          mSlot = laneQ[j].pop_front();
          checkOutput($sformatf("lane%0d_arrival_cycle", j), 64'(cycle), 64'(mSlot.cyc + 1 + j));
          checkOutput($sformatf("lane%0d_en_done", j), 64'({cal_en[j], cal_done[j]}), 64'({mSlot.en, mSlot.dn}));
          checkOutput($sformatf("h_lane%0d", j), 64'(mH), 64'(mSlot.h));
          checkOutput($sformatf("v_lane%0d", j), 64'(mV), 64'(mSlot.v));
        end
      end else begin
        checkOutput($sformatf("lane%0d_idle_data", j), 64'({mH, mV}), 64'd0);
        if (laneQ[j].size() > 0 && laneQ[j][0].cyc + 1 + j < cycle) begin
          failNow($sformatf("lane%0d_missed_slot", j), cycle, laneQ[j][0].cyc + 1 + j);
          void'(laneQ[j].pop_front());
        end
      end
    end
    if (done) begin
      if (doneQ.size() == 0) failNow("done_unexpected", cycle, -1);
      else checkOutput("done_cycle", 64'(cycle), 64'(doneQ.pop_front()));
    end else if (doneQ.size() > 0 && doneQ[0] < cycle) begin
      failNow("done_missed", cycle, doneQ[0]);
      void'(doneQ.pop_front());
    end
  end

  task automatic driveBus(input bit fixedData);
    for (int i = 0; i < R; i++) a_vec[i*DW +: DW] = fixedData ? DW'(i + 1) : DW'($urandom);
    for (int j = 0; j < C; j++) b_vec[j*DW +: DW] = fixedData ? DW'(j + 5) : DW'($urandom);
  endtask

  task automatic pushSlot(input logic en, input logic dn, input logic pass);
    slot_t s;
    for (int j = 0; j < C; j++) begin
      s.cyc = cycle;
      s.en  = en;
      s.dn  = dn;
      s.h   = pass ? a_vec[j*DW +: DW] : '0;
      s.v   = pass ? b_vec[j*DW +: DW] : '0;
      laneQ[j].push_back(s);
    end
  endtask

  task automatic applyReset();
    start = 1'b0;
    in_valid = 1'b0;
    sys_rst = 1'b1;
    expBusy = 1'b0;
    expReady = 1'b0;
    expMode = 2'b00;
    for (int j = 0; j < C; j++) laneQ[j].delete();
    doneQ.delete();
    #1;
    checkOutput("reset_status", 64'({busy, done, in_ready, PE_mode, cal_en, cal_done}), 64'd0);
    checkOutput("reset_h_data", 64'(h_data), 64'd0);
    checkOutput("reset_v_data", 64'(v_data), 64'd0);
    step();
    sys_rst = 1'b0;
  endtask

  task automatic idleCycle();
    driveBus(1'b0);
    start = ($urandom_range(0, 1) == 1);
    k_len = 8'd0;
    mode_in = 2'($urandom);
    in_valid = 1'($urandom);
    expBusy = 1'b0;
    expReady = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int k, input logic [1:0] mode, input bit randValid,
                               input logic [31:0] mask, input bit fixedData,
                               input bit busyStart, input int abortAt);
    int   beats = 0;
    int   idx = 0;
    logic v;
    driveBus(fixedData);
    start = 1'b1;
    k_len = 8'(k);
    mode_in = mode;
    in_valid = 1'b0;
    expBusy = 1'b0;
    expReady = 1'b0;
    step();
    expMode = mode;
    while (beats < k) begin
      if (idx == abortAt) begin
        applyReset();
        return;
      end
      v = randValid ? ($urandom_range(0, 3) != 0) : ((idx < 32) ? mask[idx] : 1'b1);
      driveBus(fixedData);
      in_valid = v;
      start = busyStart;
      k_len = 8'($urandom_range(1, 9));
      mode_in = 2'($urandom);
      expBusy = 1'b1;
      expReady = 1'b1;
      pushSlot(1'b1, 1'b0, v);
      if (v) beats++;
      idx++;
      step();
    end
    driveBus(fixedData);
    in_valid = 1'($urandom);
    start = busyStart;
    expReady = 1'b0;
    pushSlot(1'b0, 1'b1, 1'b0);
    doneQ.push_back(cycle + 1 + D);
    step();
    for (int d = 0; d < D; d++) begin
      driveBus(1'b0);
      in_valid = 1'($urandom);
      start = busyStart;
      step();
    end
    start = 1'b0;
    in_valid = 1'b0;
    expBusy = 1'b0;
    expReady = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    start = 1'b0;
    k_len = 8'd0;
    mode_in = 2'b00;
    in_valid = 1'b0;
    a_vec = '0;
    b_vec = '0;
    #3;
    checkOutput("initial_reset_status", 64'({busy, done, in_ready, PE_mode, cal_en, cal_done}), 64'd0);
    step();
    step();
    sys_rst = 1'b0;
    step();

    // start with k_len=0 must be ignored
    start = 1'b1;
    k_len = 8'd0;
    mode_in = 2'b11;
    step();
    start = 1'b0;
    idleCycle();

    applyStimulus(3, 2'b01, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, -1);
    idleCycle();
    applyStimulus(2, 2'b10, 1'b0, 32'b101, 1'b1, 1'b1, -1);
    applyStimulus(2, 2'b00, 1'b1, 32'd0, 1'b0, 1'b0, -1);
    applyStimulus(3, 2'b11, 1'b1, 32'd0, 1'b0, 1'b0, -1);
    idleCycle();
    applyStimulus(5, 2'b01, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);
    idleCycle();
    applyStimulus(2, 2'b10, 1'b1, 32'd0, 1'b0, 1'b0, -1);

    for (int n = 0; n < 12; n++) begin
      applyStimulus($urandom_range(1, 7), 2'($urandom), 1'b1, 32'd0, 1'b0,
                    1'($urandom), -1);
      for (int g = $urandom_range(0, 2); g > 0; g--) idleCycle();
    end

    for (int t = 0; t < D + 3; t++) idleCycle();
    for (int j = 0; j < C; j++)
      checkOutput($sformatf("lane%0d_queue_empty", j), 64'(laneQ[j].size()), 64'd0);
    checkOutput("done_queue_empty", 64'(doneQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/rsa_feeder.md
RSA_FEEDER -- requirements
Module: rsa_feeder

Interface
REQ-001 SHALL have parameter RSA_DW, default 16, meaning element width.
REQ-002 SHALL have parameter ROWS, default 4, meaning the array row count (W-edge lanes).
REQ-003 SHALL have parameter COLS, default 4, meaning the array column count (N-edge lanes).
REQ-004 SHALL have ports:
- clk  in  1  clock.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a job.
- k_len  in  8  products per PE for the job.
- mode_in  in  2  PE_mode for the job.
- busy  out  1  job in progress.
- done  out  1  one-cycle end-of-job pulse.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- a_vec  in  ROWS*RSA_DW  row operands; lane i = bits [i*RSA_DW +: RSA_DW].
- b_vec  in  COLS*RSA_DW  column operands; lane j packed the same way.
- PE_mode  out  2  mode broadcast to the array.
- h_data  out  ROWS*RSA_DW  W-edge row data, skewed.
- v_data  out  COLS*RSA_DW  N-edge column data, skewed.
- cal_en  out  COLS  per-column calculate enable, skewed.
- cal_done  out  COLS  per-column accumulate-close strobe, skewed.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, TAIL, DRAIN.
REQ-006 IDLE: on start=1 and k_len!=0, SHALL latch k_len and mode_in, set beat count to 0, and go to RUN; start with k_len=0 SHALL be ignored.
REQ-007 start SHALL be ignored in any state other than IDLE.
REQ-008 PE_mode SHALL update from mode_in one cycle after start is accepted and SHALL hold until the next accepted start.
REQ-009 in_ready SHALL be 1 only in RUN.
REQ-010 Each RUN cycle SHALL produce one stage-0 slot registered at the next edge:
- accepted beat: cal_en=1, h/v lanes = a_vec/b_vec.
- no beat (bubble): cal_en=1, all h/v lanes 0.
- cal_done=0 in both cases.
REQ-011 A bubble SHALL contribute a zero product, so the accumulation continues and rows and columns stay aligned.
REQ-012 The beat count SHALL increment on accepted beats only; the accepted beat that makes the count equal k_len SHALL move the FSM to TAIL.
REQ-013 TAIL SHALL last one cycle and produce a stage-0 slot with cal_en=0, cal_done=1 and data 0.
REQ-014 DRAIN SHALL last max(ROWS,COLS)-1 cycles and produce stage-0 slots of all zeros; it SHALL then return to IDLE and pulse done for one cycle.
REQ-015 busy SHALL be 1 in RUN, TAIL and DRAIN.
REQ-016 Skew: row lane i SHALL be delayed by i cycles; column lane j (v_data, cal_en, cal_done) SHALL be delayed by j cycles. For example, a slot created in cycle t appears on lane i/j at t+1+i/t+1+j.
REQ-017 Skew shift registers SHALL shift every cycle and never stall.
REQ-018 With ROWS=COLS=1, DRAIN SHALL last 0 cycles, going directly from TAIL to IDLE with done.
REQ-019 An accepted start SHALL not return the FSM to IDLE until DRAIN completes.

Reset
REQ-020 sys_rst=1 SHALL asynchronously force:
- FSM to IDLE and beat count to 0;
- busy, done and in_ready to 0;
- PE_mode to 0;
- all skew registers, h_data, v_data, cal_en and cal_done to 0.
REQ-021 Reset during RUN/TAIL/DRAIN SHALL abort the job with no done pulse; the first start after release SHALL be honoured.

Verification
REQ-022 ROWS=COLS=4, start k_len=3 mode_in=2'b01, in_valid held high, beats with a lanes {1,2,3,4} and b lanes {5,6,7,8} -> PE_mode=01 one cycle after start; cal_en[0] high 3 cycles then cal_done[0] 1 cycle; cal_en[3] is the same waveform shifted 3 cycles; done 3 cycles after TAIL.
REQ-023 k_len=2 with in_valid low on the 2nd RUN cycle -> stage-0 pattern data, bubble(0, cal_en=1), data, TAIL; h_data lanes 0 in the bubble slot.
REQ-024 start with k_len=0, and a second start while busy -> no state change, no done, PE_mode unchanged.
REQ-025 sys_rst asserted mid-RUN -> all outputs 0 immediately (before the next clk edge), no done; a new start afterwards produces a normal job.
REQ-026 Back-to-back jobs with mode_in 00 then 11 -> PE_mode changes only after the first job's done, and at least one cycle before the second job's first cal_en[0].
